// File: rtl/run_splitter.sv
// run_splitter: splits a key stream into zero-terminated runs of RUN_LEN keys,
// alternating between two show-ahead lane buffers (lane 1, lane 2).
// Optional feature: define RUN_SPLITTER_ORDER_CHECK_EN to build the sticky
// ascending-order checker driving o_order_err; otherwise o_order_err is 0.
module run_splitter #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned DEPTH   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_flush,
  output logic [31:0] o_fifo_1,
  output logic [31:0] o_fifo_2,
  output logic        o_fifo_1_empty,
  output logic        o_fifo_2_empty,
  input  logic        i_fifo_1_read,
  input  logic        i_fifo_2_read,
  output logic        o_order_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [7:0]  LAST_IDX = 8'(RUN_LEN - 1);
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {FILL_1, TERM_1, FILL_2, TERM_2} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt_next;

  logic [31:0] r_mem1 [DEPTH];
  logic [31:0] r_mem2 [DEPTH];
  logic [AW:0] r_wp1, r_rp1, r_wp2, r_rp2;

  logic        w_full1, w_full2, w_empty1, w_empty2;
  logic        w_fill1, w_fill2, w_accept;
  logic        w_wr1, w_wr2, w_pop1, w_pop2;
  logic [31:0] w_wd1, w_wd2;

  assign w_empty1 = (r_wp1 == r_rp1);
  assign w_empty2 = (r_wp2 == r_rp2);
  assign w_full1  = ((r_wp1 - r_rp1) == FULL_OCC);
  assign w_full2  = ((r_wp2 - r_rp2) == FULL_OCC);

  assign w_fill1  = (r_state == FILL_1);
  assign w_fill2  = (r_state == FILL_2);
  assign o_ready  = ((w_fill1 & ~w_full1) | (w_fill2 & ~w_full2)) & ~i_rst;
  assign w_accept = i_valid & o_ready;

  // Lane writes: accepted key in FILL_x, terminator 0 in TERM_x when space
  assign w_wr1 = (w_fill1 & w_accept) | ((r_state == TERM_1) & ~w_full1);
  assign w_wr2 = (w_fill2 & w_accept) | ((r_state == TERM_2) & ~w_full2);
  assign w_wd1 = (r_state == TERM_1) ? '0 : i_data;
  assign w_wd2 = (r_state == TERM_2) ? '0 : i_data;
  assign w_pop1 = i_fifo_1_read & ~w_empty1;
  assign w_pop2 = i_fifo_2_read & ~w_empty2;

  // Heads are gated to 0 while empty so they read 0 after reset
  assign o_fifo_1       = w_empty1 ? '0 : r_mem1[r_rp1[AW-1:0]];
  assign o_fifo_2       = w_empty2 ? '0 : r_mem2[r_rp2[AW-1:0]];
  assign o_fifo_1_empty = w_empty1;
  assign o_fifo_2_empty = w_empty2;

  // FSM state and run counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FILL_1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state: close a run on the RUN_LEN-th key or on a flush of a non-empty run
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      FILL_1, FILL_2: begin
        if (w_accept) begin
          if (r_cnt == LAST_IDX) begin
            w_next     = w_fill1 ? TERM_1 : TERM_2;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        if (i_flush && (r_cnt != '0)) begin
          w_next     = w_fill1 ? TERM_1 : TERM_2;
          w_cnt_next = '0;
        end
      end
      TERM_1: if (!w_full1) w_next = FILL_2;
      TERM_2: if (!w_full2) w_next = FILL_1;
      default: w_next = FILL_1;
    endcase
  end

  // Lane pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp1 <= '0;
      r_rp1 <= '0;
      r_wp2 <= '0;
      r_rp2 <= '0;
    end else begin
      if (w_wr1)  r_wp1 <= r_wp1 + 1'b1;
      if (w_pop1) r_rp1 <= r_rp1 + 1'b1;
      if (w_wr2)  r_wp2 <= r_wp2 + 1'b1;
      if (w_pop2) r_rp2 <= r_rp2 + 1'b1;
    end
  end

  // Lane storage, no reset needed since heads are gated while empty
  always_ff @(posedge i_clk) begin
    if (w_wr1) r_mem1[r_wp1[AW-1:0]] <= w_wd1;
    if (w_wr2) r_mem2[r_wp2[AW-1:0]] <= w_wd2;
  end

`ifdef RUN_SPLITTER_ORDER_CHECK_EN
  logic [31:0] r_prev;
  logic        r_err;

  // Sticky flag: zero key, or key below the previous key of the same run
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      if ((i_data == '0) || ((r_cnt != '0) && (i_data < r_prev))) r_err <= 1'b1;
      r_prev <= i_data;
    end
  end

  assign o_order_err = r_err;
`else
  assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_run_splitter.sv
// Testbench for run_splitter (RUN_LEN=4, DEPTH=16): table-driven vectors plus
// hand-written sequences for lane-full back-pressure and the order checker.
module tb_run_splitter;

  logic        clk = 1'b0;
  logic        rst, valid, flush, rd1, rd2;
  logic [31:0] data;
  logic        ready, e1, e2, err;
  logic [31:0] h1, h2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, valid;
    logic [31:0] data;
    logic        flush, rd1, rd2;
    logic        ready, e1, e2;
    logic [31:0] h1, h2;
  } vec_t;

  vec_t vecs[$];

  run_splitter #(.RUN_LEN(4), .DEPTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(ready),
    .i_flush(flush), .o_fifo_1(h1), .o_fifo_2(h2),
    .o_fifo_1_empty(e1), .o_fifo_2_empty(e2),
    .i_fifo_1_read(rd1), .i_fifo_2_read(rd2), .o_order_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [31:0] d, input logic f,
                     input logic p1, input logic p2, input logic erdy, input logic ee1,
                     input logic ee2, input logic [31:0] eh1, input logic [31:0] eh2);
    vec_t t;
    t = '{rst: r, valid: v, data: d, flush: f, rd1: p1, rd2: p2,
          ready: erdy, e1: ee1, e2: ee2, h1: eh1, h2: eh2};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic f,
                       input logic p1, input logic p2);
    @(negedge clk);
    rst = r; valid = v; data = d; flush = f; rd1 = p1; rd2 = p2;
    #1;
  endtask

  logic exp_err;

  initial begin
    rst = 1'b1; valid = 1'b0; data = '0; flush = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_e1", 32'(e1), 32'd1);
    chk("reset_e2", 32'(e2), 32'd1);
    chk("reset_h1", h1, 32'd0);
    chk("reset_h2", h2, 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    //   rst v  data f  rd1 rd2 | rdy e1 e2 h1 h2
    // Two full runs of 4, then drain both lanes
    add(0, 1, 1,  0, 0, 0,  1, 1, 1, 0, 0);
    add(0, 1, 2,  0, 0, 0,  1, 0, 1, 1, 0);
    add(0, 1, 3,  0, 0, 0,  1, 0, 1, 1, 0);
    add(0, 1, 4,  0, 0, 0,  1, 0, 1, 1, 0);
    add(0, 1, 5,  0, 0, 0,  0, 0, 1, 1, 0);
    add(0, 1, 5,  0, 0, 0,  1, 0, 1, 1, 0);
    add(0, 1, 6,  0, 0, 0,  1, 0, 0, 1, 5);
    add(0, 1, 7,  0, 0, 0,  1, 0, 0, 1, 5);
    add(0, 1, 8,  0, 0, 0,  1, 0, 0, 1, 5);
    add(0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 5);
    add(0, 0, 0,  0, 1, 0,  1, 0, 0, 1, 5);
    add(0, 0, 0,  0, 1, 0,  1, 0, 0, 2, 5);
    add(0, 0, 0,  0, 1, 0,  1, 0, 0, 3, 5);
    add(0, 0, 0,  0, 1, 0,  1, 0, 0, 4, 5);
    add(0, 0, 0,  0, 1, 0,  1, 0, 0, 0, 5);
    add(0, 0, 0,  0, 0, 1,  1, 1, 0, 0, 5);
    add(0, 0, 0,  0, 0, 1,  1, 1, 0, 0, 6);
    add(0, 0, 0,  0, 0, 1,  1, 1, 0, 0, 7);
    add(0, 0, 0,  0, 0, 1,  1, 1, 0, 0, 8);
    add(0, 0, 0,  0, 0, 1,  1, 1, 0, 0, 0);
    add(0, 0, 0,  0, 0, 1,  1, 1, 1, 0, 0);
    // Flush after 10,20; pop of empty lane 2 while writing lane 1
    add(0, 1, 10, 0, 0, 1,  1, 1, 1, 0, 0);
    add(0, 1, 20, 0, 0, 0,  1, 0, 1, 10, 0);
    add(0, 0, 0,  1, 0, 0,  1, 0, 1, 10, 0);
    add(0, 1, 30, 0, 0, 0,  0, 0, 1, 10, 0);
    add(0, 1, 30, 0, 0, 0,  1, 0, 1, 10, 0);
    add(0, 0, 0,  0, 0, 0,  1, 0, 0, 10, 30);
    add(0, 0, 0,  0, 1, 0,  1, 0, 0, 10, 30);
    add(0, 0, 0,  0, 1, 0,  1, 0, 0, 20, 30);
    add(0, 0, 0,  0, 1, 0,  1, 0, 0, 0, 30);
    add(0, 0, 0,  0, 0, 1,  1, 1, 0, 0, 30);
    // Reset mid-run in lane 2: no terminator, next key lands in lane 1
    add(0, 1, 40, 0, 0, 0,  1, 1, 1, 0, 0);
    add(1, 0, 0,  0, 0, 0,  0, 1, 0, 0, 40);
    add(0, 1, 50, 0, 0, 0,  1, 1, 1, 0, 0);
    add(0, 0, 0,  0, 1, 0,  1, 0, 1, 50, 0);
    add(1, 0, 0,  0, 0, 0,  0, 1, 1, 0, 0);
    // Flush with empty run is ignored
    add(0, 0, 0,  1, 0, 0,  1, 1, 1, 0, 0);
    add(0, 1, 60, 0, 0, 0,  1, 1, 1, 0, 0);
    add(0, 0, 0,  0, 0, 0,  1, 0, 1, 60, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].flush, vecs[i].rd1, vecs[i].rd2);
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].ready));
      chk($sformatf("v%0d_e1", i), 32'(e1), 32'(vecs[i].e1));
      chk($sformatf("v%0d_e2", i), 32'(e2), 32'(vecs[i].e2));
      chk($sformatf("v%0d_h1", i), h1, vecs[i].h1);
      chk($sformatf("v%0d_h2", i), h2, vecs[i].h2);
    end

    // Order checker: 5 then 3 within one run
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 0, 0, 0);
    chk("ord_err_before", 32'(err), 32'd0);
    drive(0, 1, 3, 0, 0, 0);
    chk("ord_err_same_cycle", 32'(err), 32'd0);
    drive(0, 1, 7, 0, 0, 0);
    chk("ord_err_set", 32'(err), 32'(exp_err));
    drive(0, 1, 8, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 1, 9, 0, 1, 0);
    chk("ord_err_sticky", 32'(err), 32'(exp_err));
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("ord_err_cleared", 32'(err), 32'd0);

    // Lane 1 never read: 16 entries (3 runs+terms, then 1 key) fill it at cycle 30
    drive(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 36; c++) begin
      logic erdy;
      erdy = ((c <= 30) && ((c % 5) != 4)) || (c == 34);
      drive(0, 1, 32'(100 + c), 0, (c == 33), 1);
      chk($sformatf("full_c%0d_ready", c), 32'(ready), 32'(erdy));
      if (c == 33) chk("full_head_before_pop", h1, 32'd100);
      if (c == 34) chk("full_head_after_pop", h1, 32'd101);
      if (c == 32) chk("full_e1", 32'(e1), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
